// File: rtl/ucie_param_negotiator_if.sv
// Sideband valid/ready stream between the parameter negotiator (master) and the
// sideband packetiser (slave): one tx word stream and one rx word stream.
interface ucie_param_negotiator_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/ucie_param_negotiator.sv
// D2D adapter parameter exchange: concurrent tx/rx of NUM_PARAMS words, per-parameter
// negotiation, timeout/checksum recovery by bounded retry. Optional: UCIE_PNEG_CHECKSUM_EN.
module ucie_param_negotiator #(
  parameter int NUM_PARAMS     = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3,
  localparam int RC_W          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_PARAMS*DATA_W-1:0] local_params,
  input  logic [2*NUM_PARAMS-1:0]      neg_mode,
  ucie_param_negotiator_if.master      sb,
  output logic [NUM_PARAMS*DATA_W-1:0] remote_params,
  output logic [NUM_PARAMS*DATA_W-1:0] neg_params,
  output logic [NUM_PARAMS-1:0]        mismatch_mask,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   error_code,
  output logic [RC_W-1:0]              retry_count
);

`ifdef UCIE_PNEG_CHECKSUM_EN
  localparam int N_WORDS = NUM_PARAMS + 1;
`else
  localparam int N_WORDS = NUM_PARAMS;
`endif
  localparam int IDX_W  = $clog2(N_WORDS + 1);
  localparam int PIDX_W = $clog2(NUM_PARAMS);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0]  N_WORDS_I  = IDX_W'(N_WORDS);
  localparam logic [IDX_W-1:0]  N_PARAMS_I = IDX_W'(NUM_PARAMS);
  localparam logic [PIDX_W-1:0] LAST_P     = PIDX_W'(NUM_PARAMS - 1);
  localparam logic [TMR_W-1:0]  TMO        = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [RC_W-1:0]   RC_MAX     = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_XFER, S_CHECK, S_RETRY, S_NEGOTIATE, S_DONE, S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    MODE_MIN = 2'b00, MODE_AND = 2'b01, MODE_EXACT = 2'b10, MODE_MAX = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    EC_NONE = 2'b00, EC_TIMEOUT = 2'b01, EC_CHECKSUM = 2'b10, EC_MISMATCH = 2'b11
  } ec_e;

  typedef logic [NUM_PARAMS-1:0][DATA_W-1:0] words_t;

  state_e                state_q, state_d;
  words_t                snap_q, snap_d;
  words_t                remote_q, remote_d;
  words_t                neg_q, neg_d;
  logic [NUM_PARAMS-1:0] mismatch_q, mismatch_d;
  logic [IDX_W-1:0]      tx_idx_q, tx_idx_d;
  logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
  logic [PIDX_W-1:0]     neg_idx_q, neg_idx_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [RC_W-1:0]       retry_q, retry_d;
  ec_e                   ec_q, ec_d;
`ifdef UCIE_PNEG_CHECKSUM_EN
  logic [DATA_W-1:0]     rx_sum_q, rx_sum_d;
  logic [DATA_W-1:0]     tx_csum;
`endif

  logic              tx_valid, rx_ready, tx_fire, rx_fire;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] l_w, r_w, neg_res;
  logic              neg_mis;

  // Stream side: word index comes straight from the registered counters, so tx_data
  // cannot change while a word is waiting for tx_ready.
  always_comb begin
    tx_valid = (state_q == S_XFER) && (tx_idx_q < N_WORDS_I);
    rx_ready = (state_q == S_XFER) && (rx_idx_q < N_WORDS_I);
    tx_word  = snap_q[tx_idx_q[PIDX_W-1:0]];
`ifdef UCIE_PNEG_CHECKSUM_EN
    tx_csum = '0;
    for (int i = 0; i < NUM_PARAMS; i++) tx_csum = tx_csum ^ snap_q[i];
    if (tx_idx_q == N_PARAMS_I) tx_word = tx_csum;
`endif
  end

  assign tx_fire     = tx_valid && sb.tx_ready;
  assign rx_fire     = rx_ready && sb.rx_valid;
  assign sb.tx_valid = tx_valid;
  assign sb.rx_ready = rx_ready;
  assign sb.tx_data  = tx_valid ? tx_word : '0;

  // One parameter per cycle; MIN/MAX compare unsigned.
  always_comb begin
    l_w     = snap_q[neg_idx_q];
    r_w     = remote_q[neg_idx_q];
    neg_res = l_w;
    neg_mis = 1'b0;
    case (neg_mode[2*neg_idx_q +: 2])
      MODE_MIN:   begin neg_res = (l_w < r_w) ? l_w : r_w; neg_mis = (neg_res == '0); end
      MODE_AND:   begin neg_res = l_w & r_w;               neg_mis = (neg_res == '0); end
      MODE_EXACT: begin neg_res = l_w;                     neg_mis = (l_w != r_w);    end
      MODE_MAX:   begin neg_res = (l_w > r_w) ? l_w : r_w; neg_mis = (neg_res == '0); end
      default:    ;
    endcase
  end

  always_comb begin
    // NOTE: every *_d starts as its *_q, so paths that do not assign it hold state
    // instead of inferring a latch.
    state_d    = state_q;
    snap_d     = snap_q;
    remote_d   = remote_q;
    neg_d      = neg_q;
    mismatch_d = mismatch_q;
    tx_idx_d   = tx_idx_q;
    rx_idx_d   = rx_idx_q;
    neg_idx_d  = neg_idx_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    ec_d       = ec_q;
`ifdef UCIE_PNEG_CHECKSUM_EN
    rx_sum_d   = rx_sum_q;
`endif

    if (abort) begin
      state_d = S_IDLE;
      ec_d    = EC_NONE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            snap_d     = local_params;
            tx_idx_d   = '0;
            rx_idx_d   = '0;
            neg_idx_d  = '0;
            timer_d    = '0;
            retry_d    = '0;
            ec_d       = EC_NONE;
            mismatch_d = '0;
`ifdef UCIE_PNEG_CHECKSUM_EN
            rx_sum_d   = '0;
`endif
            state_d    = S_XFER;
          end
        end
        S_XFER: begin
          if (timer_q == TMO) begin
            ec_d    = EC_TIMEOUT;
            state_d = S_RETRY;
          end else if ((tx_idx_q == N_WORDS_I) && (rx_idx_q == N_WORDS_I)) begin
            neg_idx_d = '0;
`ifdef UCIE_PNEG_CHECKSUM_EN
            state_d   = S_CHECK;
`else
            state_d   = S_NEGOTIATE;
`endif
          end else begin
            if (tx_fire) tx_idx_d = tx_idx_q + 1'b1;
            if (rx_fire) begin
              if (rx_idx_q < N_PARAMS_I) remote_d[rx_idx_q[PIDX_W-1:0]] = sb.rx_data;
`ifdef UCIE_PNEG_CHECKSUM_EN
              rx_sum_d = rx_sum_q ^ sb.rx_data;
`endif
              rx_idx_d = rx_idx_q + 1'b1;
              timer_d  = '0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
`ifdef UCIE_PNEG_CHECKSUM_EN
        // Checksum word was folded into rx_sum as well, so a clean frame sums to zero.
        S_CHECK: begin
          if (rx_sum_q == '0) begin
            state_d = S_NEGOTIATE;
          end else begin
            ec_d    = EC_CHECKSUM;
            state_d = S_RETRY;
          end
        end
`endif
        S_RETRY: begin
          if (retry_q == RC_MAX) begin
            state_d = S_ERROR;
          end else begin
            retry_d  = retry_q + 1'b1;
            tx_idx_d = '0;
            rx_idx_d = '0;
            timer_d  = '0;
            ec_d     = EC_NONE;
`ifdef UCIE_PNEG_CHECKSUM_EN
            rx_sum_d = '0;
`endif
            state_d  = S_XFER;
          end
        end
        S_NEGOTIATE: begin
          neg_d[neg_idx_q]      = neg_res;
          mismatch_d[neg_idx_q] = neg_mis;
          if (neg_idx_q == LAST_P) begin
            if ((|mismatch_q) || neg_mis) begin
              ec_d    = EC_MISMATCH;
              state_d = S_ERROR;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            neg_idx_d = neg_idx_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: snapshot/remote/negotiated words are visible state, so they are reset too,
  // not just the control flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      snap_q     <= '0;
      remote_q   <= '0;
      neg_q      <= '0;
      mismatch_q <= '0;
      tx_idx_q   <= '0;
      rx_idx_q   <= '0;
      neg_idx_q  <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      ec_q       <= EC_NONE;
`ifdef UCIE_PNEG_CHECKSUM_EN
      rx_sum_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      remote_q   <= remote_d;
      neg_q      <= neg_d;
      mismatch_q <= mismatch_d;
      tx_idx_q   <= tx_idx_d;
      rx_idx_q   <= rx_idx_d;
      neg_idx_q  <= neg_idx_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      ec_q       <= ec_d;
`ifdef UCIE_PNEG_CHECKSUM_EN
      rx_sum_q   <= rx_sum_d;
`endif
    end
  end

  assign remote_params = remote_q;
  assign neg_params    = neg_q;
  assign mismatch_mask = mismatch_q;
  assign retry_count   = retry_q;
  assign error_code    = ec_q;
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERROR);
  assign busy          = (state_q == S_XFER) || (state_q == S_CHECK) ||
                         (state_q == S_RETRY) || (state_q == S_NEGOTIATE);

endmodule
